nrzi_ddr_rx_deframer: RTL and testbench

- Receive side of the NRZI DDR serial link: decodes two NRZI bit periods per clkp cycle back to plain bits.
- Hunts for a start bit, assembles fixed-width words MSB first and flags the last word of each frame.
- Sits behind an external input-DDR primitive that presents both half-cycle line samples on clkp.
- Output feeds the HPU event path. The line cannot stall, so there is no backpressure.

---
 rtl/nrzi_ddr_rx_deframer.sv | 87 ++++++++
 tb/tb_nrzi_ddr_rx_deframer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/nrzi_ddr_rx_deframer.sv
// nrzi_ddr_rx_deframer: decodes two NRZI bit periods per clkp cycle and deframes
// start/data/continuation words, MSB first, with a registered one-cycle word pulse.
module nrzi_ddr_rx_deframer #(
  parameter int DATA_W = 8
) (
  input  logic              clkp,
  input  logic              _rst,
  input  logic [1:0]        samp,
  input  logic              en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, DATA, CONT} state_t;
  typedef struct packed {
    state_t            st;
    logic [DATA_W-1:0] sh;
    logic [CW-1:0]     cnt;
    logic              emit;
    logic              last;
    logic [DATA_W-1:0] word;
  } fsm_t;
  state_t            st_q, st_d;
  logic [1:0]        s_q, bits;
  logic              prev_q, emit_d;
  logic [DATA_W-1:0] sh_q, out_data_q;
  logic [CW-1:0]     cnt_q;
  logic              out_valid_q, out_last_q, busy_q;
  fsm_t              f0, f1, f2;
  // One consumed bit; applied twice per cycle so both half-cycle bits advance the FSM.
  function automatic fsm_t step(input fsm_t f, input logic b);
    step = f;
    if (f.st == IDLE) begin
      if (b) begin
        step.st  = DATA;
        step.cnt = '0;
      end
    end else if (f.st == DATA) begin
      step.sh  = {f.sh[DATA_W-2:0], b};
      step.cnt = f.cnt + 1'b1;
      if (step.cnt == CW'(DATA_W)) step.st = CONT;
    end else begin
      step.emit = 1'b1;
      step.word = f.sh;
      step.last = ~b;
      step.st   = b ? DATA : IDLE;
      step.cnt  = '0;
    end
  endfunction
  assign bits = {s_q[1] ^ prev_q, s_q[0] ^ s_q[1]};
  always_comb begin
    f0     = '{st: st_q, sh: sh_q, cnt: cnt_q, emit: 1'b0, last: 1'b0, word: sh_q};
    f1     = step(f0, bits[1]);
    f2     = step(f1, bits[0]);
    st_d   = en ? f2.st : IDLE;
    emit_d = en & f2.emit;
  end
  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) begin
      s_q         <= '0;
      prev_q      <= 1'b0;
      st_q        <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s_q         <= samp;
      prev_q      <= s_q[0];
      st_q        <= st_d;
      sh_q        <= f2.sh;
      cnt_q       <= f2.cnt;
      out_valid_q <= emit_d;
      out_data_q  <= emit_d ? f2.word : out_data_q;
      out_last_q  <= emit_d ? f2.last : out_last_q;
      busy_q      <= st_d != IDLE;
    end
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_nrzi_ddr_rx_deframer.sv
// tb_nrzi_ddr_rx_deframer: builds logical bit streams of frames, NRZI-encodes them onto samp
// and predicts each word pulse and busy window from where the frame bits sit in the stream.
module tb_nrzi_ddr_rx_deframer;
  logic        clkp = 1'b0, _rst = 1'b0, en = 1'b1;
  logic [1:0]  samp = 2'b00;
  logic [7:0]  d8;
  logic        v8, l8, b8;
  logic [4:0]  d5;
  logic        v5, l5, b5;
  logic        sel5 = 1'b0, lvl = 1'b0;
  int          w = 8;
  logic        ov, ol, ob;
  logic [31:0] od;
  int          n_tests = 0, n_fail = 0;
  logic        bq[$];
  bit          ev[1024], el[1024], eb[1024];
  logic [31:0] ed[1024];
  nrzi_ddr_rx_deframer #(.DATA_W(8)) dut8 (.clkp(clkp), ._rst(_rst), .samp(samp), .en(en),
    .out_data(d8), .out_valid(v8), .out_last(l8), .busy(b8));
  nrzi_ddr_rx_deframer #(.DATA_W(5)) dut5 (.clkp(clkp), ._rst(_rst), .samp(samp), .en(en),
    .out_data(d5), .out_valid(v5), .out_last(l5), .busy(b5));
  always #5 clkp = ~clkp;
  assign ov = sel5 ? v5 : v8;
  assign ol = sel5 ? l5 : l8;
  assign ob = sel5 ? b5 : b8;
  assign od = sel5 ? {27'b0, d5} : {24'b0, d8};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (w=%0d, t=%0t)", tag, got, exp, w, $time);
    end
  endtask
  task automatic add_gap(input int n);
    repeat (n) bq.push_back(1'b0);
  endtask
  // Cont bit at stream index k is registered into s_q after pair k/2, pulse seen two cycles on.
  task automatic add_frame(input int n, input logic [31:0] w0, input logic [31:0] w1 = 0,
                           input logic [31:0] w2 = 0);
    int s, k;
    s = bq.size();
    k = s;
    bq.push_back(1'b1);
    for (int i = 0; i < n; i++) begin
      logic [31:0] m;
      m = (i == 0 ? w0 : i == 1 ? w1 : w2) & ((32'd1 << w) - 1);
      for (int j = w - 1; j >= 0; j--) bq.push_back(m[j]);
      k = bq.size();
      bq.push_back(i != n - 1);
      ev[k/2+2] = 1'b1;
      ed[k/2+2] = m;
      el[k/2+2] = (i == n - 1);
    end
    for (int p = s/2 + 2; p <= k/2 + 1; p++) eb[p] = 1'b1;
  endtask
  task automatic run_stream(input int stop_at = -1, input bit chk_busy = 1'b1,
                            input int en_lo = -1, input int en_hi = -1);
    int np;
    logic b1, b0, l1, l0;
    add_gap(8);
    if (bq.size() % 2 != 0) add_gap(1);
    np = bq.size() / 2;
    for (int p = 0; p <= np + 2; p++) begin
      @(negedge clkp);
      if (p == stop_at) begin
        #1 _rst = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, ov}, 0);
        check("rst_mid_data", od, 0);
        check("rst_mid_last", {31'b0, ol}, 0);
        check("rst_mid_busy", {31'b0, ob}, 0);
        break;
      end
      check("valid", {31'b0, ov}, {31'b0, ev[p]});
      if (ev[p]) begin
        check("data", od, ed[p]);
        check("last", {31'b0, ol}, {31'b0, el[p]});
      end
      if (chk_busy) check("busy", {31'b0, ob}, {31'b0, eb[p]});
      b1 = (2*p < bq.size()) ? bq[2*p] : 1'b0;
      b0 = (2*p + 1 < bq.size()) ? bq[2*p+1] : 1'b0;
      l1 = lvl ^ b1;
      l0 = l1 ^ b0;
      lvl = l0;
      samp = {l1, l0};
      en = !(p >= en_lo && p < en_hi);
    end
    bq.delete();
    foreach (ev[i]) begin
      ev[i] = 1'b0;
      el[i] = 1'b0;
      eb[i] = 1'b0;
      ed[i] = '0;
    end
  endtask
  task automatic do_reset();
    @(negedge clkp);
    _rst = 1'b0;
    samp = 2'b00;
    lvl = 1'b0;
    en = 1'b1;
    #1;
    check("rst_valid", {31'b0, ov}, 0);
    check("rst_data", od, 0);
    check("rst_last", {31'b0, ol}, 0);
    check("rst_busy", {31'b0, ob}, 0);
    repeat (2) @(negedge clkp);
    _rst = 1'b1;
  endtask
  task automatic random_streams(input int n);
    repeat (n) begin
      int nf;
      nf = $urandom_range(1, 4);
      repeat (nf) begin
        add_gap($urandom_range(0, 6));
        add_frame($urandom_range(1, 3), $urandom, $urandom, $urandom);
      end
      run_stream();
    end
  endtask
  initial begin
    do_reset();
    add_gap(4); add_frame(1, 32'hA5); run_stream();
    add_gap(5); add_frame(1, 32'hA5); run_stream();
    add_gap(2); add_frame(3, 32'h3C, 32'hFF, 32'h01); run_stream();
    add_gap(1); add_frame(1, 32'h96); add_frame(1, 32'h80); run_stream();
    add_gap(2);
    bq.push_back(1'b1); bq.push_back(1'b1); bq.push_back(1'b0);
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b0);
    add_gap(20);
    run_stream(-1, 1'b0, 4, 10);
    @(negedge clkp);
    check("abort_busy", {31'b0, ob}, 0);
    check("abort_valid", {31'b0, ov}, 0);
    add_gap(3); add_frame(1, 32'h5A); run_stream();
    random_streams(12);
    add_gap(2); add_frame(1, 32'h77); add_gap(3); add_frame(1, 32'hEE); run_stream(11);
    do_reset();
    add_gap(3); add_frame(1, 32'hC3); run_stream();
    sel5 = 1'b1;
    w = 5;
    do_reset();
    add_gap(2); add_frame(1, 32'h0B); add_gap(3); add_frame(1, 32'h1C); run_stream(9);
    do_reset();
    add_gap(3); add_frame(1, 32'h15); run_stream();
    add_gap(1); add_frame(2, 32'h1F, 32'h01); run_stream();
    random_streams(6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
